// File: rtl/riscv_hazard_scoreboard_if.sv
// Pipeline <-> hazard unit bundle: register indices and write enables per stage, memory handshake,
// and the hazard unit's forwarding, stall, flush and status outputs.
interface riscv_hazard_scoreboard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic [REG_ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
   logic [REG_ADDR_W-1:0] RdE, RdM, RdW;
   logic                  RegWriteE, RegWriteM, RegWriteW;
   logic [1:0]            ResultSrcE;
   logic                  PCSrcE;
   logic                  MemReqM, MemAckM;
   logic [1:0]            ForwardAE, ForwardBE;
   logic                  StallF, StallD, StallE, StallM;
   logic                  FlushD, FlushE, FlushW;
   logic                  MemBusy, MemTimeout;
   logic [CNT_W-1:0]      StallCycles;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemBusy, MemTimeout, StallCycles
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemBusy, MemTimeout, StallCycles
   );
endinterface

// File: rtl/riscv_hazard_scoreboard.sv
// 5-stage RISC-V hazard unit: forwarding selects, load-use/RAW stalls, branch flushes, memory-wait FSM.
// Forward/stall/flush are combinational (0 cycles); MemBusy, MemTimeout, StallCycles registered; no handshake backpressure of its own.
module riscv_hazard_scoreboard #(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_LAT_MAX = 4,
   parameter int FWD_EN      = 1,
   parameter int CNT_W       = 16
) (
   input logic                      clk,
   input logic                      reset,
   riscv_hazard_scoreboard_if.slave hz
);
   localparam int               LAT_W   = $clog2(MEM_LAT_MAX + 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT_MAX);

   typedef enum logic {MEM_IDLE, MEM_WAIT} memState_t;

   memState_t        state, stateNext;
   logic [LAT_W-1:0] latCnt, latCntNext;
   logic             timeoutSet;
   logic             timeoutFlag;
   logic [CNT_W-1:0] stallCnt;
   logic [1:0]       fwdA, fwdB;
   logic             hitE, hitM, dataStall;
   logic             memWait, br, dStall;
   logic             stallFD;

   function automatic logic hit(input logic we, input logic [REG_ADDR_W-1:0] rd,
                                input logic [REG_ADDR_W-1:0] r);
      return we && (rd != '0) && (rd == r);
   endfunction

   always_comb begin
      fwdA = 2'b00;
      fwdB = 2'b00;
      if (FWD_EN != 0) begin
         if (hit(hz.RegWriteM, hz.RdM, hz.Rs1E))      fwdA = 2'b10;
         else if (hit(hz.RegWriteW, hz.RdW, hz.Rs1E)) fwdA = 2'b01;
         if (hit(hz.RegWriteM, hz.RdM, hz.Rs2E))      fwdB = 2'b10;
         else if (hit(hz.RegWriteW, hz.RdW, hz.Rs2E)) fwdB = 2'b01;
      end
   end

   // With forwarding only a load in E can't be bypassed in time; without it any E/M writer blocks D.
   always_comb begin
      hitE = hit(hz.RegWriteE, hz.RdE, hz.Rs1D) || hit(hz.RegWriteE, hz.RdE, hz.Rs2D);
      hitM = hit(hz.RegWriteM, hz.RdM, hz.Rs1D) || hit(hz.RegWriteM, hz.RdM, hz.Rs2D);
      if (FWD_EN != 0) dataStall = hitE && (hz.ResultSrcE == 2'b01);
      else             dataStall = hitE || hitM;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= MEM_IDLE;
         latCnt <= '0;
      end else begin
         state  <= stateNext;
         latCnt <= latCntNext;
      end
   end

   always_comb begin
      stateNext  = state;
      latCntNext = latCnt;
      timeoutSet = 1'b0;
      case (state)
         MEM_IDLE: begin
            if (hz.MemReqM && !hz.MemAckM) begin
               stateNext  = MEM_WAIT;
               latCntNext = LAT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (hz.MemAckM) begin
               stateNext  = MEM_IDLE;
               latCntNext = '0;
            end else if (latCnt == LAT_MAX) begin
               timeoutSet = 1'b1;
               stateNext  = MEM_IDLE;
               latCntNext = '0;
            end else begin
               latCntNext = latCnt + LAT_W'(1);
            end
         end
         default: begin
            stateNext  = MEM_IDLE;
            latCntNext = '0;
         end
      endcase
   end

   // A branch under a memory wait is held off until the wait ends; a taken branch kills D, so no load-use stall.
   always_comb begin
      memWait = (state == MEM_WAIT) && !hz.MemAckM;
      br      = hz.PCSrcE && !memWait;
      dStall  = dataStall && !memWait && !br;
      stallFD = reset && (memWait || dStall);

      hz.ForwardAE = reset ? fwdA : 2'b00;
      hz.ForwardBE = reset ? fwdB : 2'b00;
      hz.StallF    = stallFD;
      hz.StallD    = stallFD;
      hz.StallE    = reset && memWait;
      hz.StallM    = reset && memWait;
      hz.FlushD    = !reset || br;
      hz.FlushE    = !reset || br || dStall;
      hz.FlushW    = !reset || memWait;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeoutFlag <= 1'b0;
         stallCnt    <= '0;
      end else begin
         if (timeoutSet)               timeoutFlag <= 1'b1;
         if (stallFD && !(&stallCnt))  stallCnt    <= stallCnt + CNT_W'(1);
      end
   end

   assign hz.MemBusy     = (state == MEM_WAIT);
   assign hz.MemTimeout  = timeoutFlag;
   assign hz.StallCycles = stallCnt;
endmodule
